// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and byte-enable helper for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [3:0] byte_en(size_t sz, logic [1:0] a);
    return sz == SZ_BYTE ? 4'b0001 << a :
           sz == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) :
           sz == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian store lane placement and load extract/extend
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wlane,
  output logic [3:0]  be,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b     = rword[{lane, 3'b000} +: 8];
    h     = lane[1] ? rword[31:16] : rword[15:0];
    be    = byte_en(size, lane);
    // replicate narrow data across all lanes; the byte enables pick the target
    wlane = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata = size == SZ_BYTE ? {{24{b[7] & ~uns}}, b} :
            size == SZ_HALF ? {{16{h[15] & ~uns}}, h} : rword;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated load/store responder; DMEM_ERR_CAPTURE_EN adds first-fault capture
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_ERR_CAPTURE_EN
  output logic        err_sticky,
  output logic [31:0] err_addr,
`endif
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic lat_we, lat_uns, cur_we, cur_uns, acc, commit, err;
  logic [31:0] lat_addr, lat_wdata, cur_addr, cur_wdata, off, rword, wlane, ldata;
  size_t lat_size, cur_size;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    acc       = req_valid && req_ready;
    nxt       = state == IDLE ? (acc ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
                state == WAIT ? (cnt == 0 ? RESP : WAIT) :
                                (rsp_ready ? IDLE : RESP);
  end
  // with zero wait states the access commits on the accept edge, straight from the bus
  assign commit    = state == WAIT ? cnt == 0 : (acc && LATENCY == 0);
  assign cur_we    = state == IDLE ? req_we : lat_we;
  assign cur_uns   = state == IDLE ? req_unsigned : lat_uns;
  assign cur_addr  = state == IDLE ? req_addr : lat_addr;
  assign cur_wdata = state == IDLE ? req_wdata : lat_wdata;
  assign cur_size  = state == IDLE ? size_t'(req_size) : lat_size;
  assign off       = cur_addr - BASE_ADDR;
  assign idx       = AW'(off >> 2);
  assign rword     = mem[idx];
  assign err       = cur_size == SZ_BAD || (cur_size == SZ_HALF && cur_addr[0]) ||
                     (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00) ||
                     cur_addr < BASE_ADDR || (off >> 2) >= 32'(DEPTH_WORDS);
  dmem_lane_align u_align (
    .size (cur_size),
    .lane (cur_addr[1:0]),
    .uns  (cur_uns),
    .wdata(cur_wdata),
    .rword(rword),
    .wlane(wlane),
    .be   (be),
    .rdata(ldata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef DMEM_ERR_CAPTURE_EN
      err_sticky <= 1'b0;
      err_addr   <= '0;
`endif
    end else begin
      state <= nxt;
      if (acc) cnt <= CW'(LATENCY - 1);
      else if (state == WAIT && cnt != 0) cnt <= cnt - 1'b1;
      if (commit) begin
        rsp_rdata <= (err || cur_we) ? 32'h0 : ldata;
        rsp_err   <= err;
      end
`ifdef DMEM_ERR_CAPTURE_EN
      if (commit && err && !err_sticky) begin
        err_sticky <= 1'b1;
        err_addr   <= cur_addr;
      end
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      lat_we    <= req_we;
      lat_uns   <= req_unsigned;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_size  <= size_t'(req_size);
    end
    if (commit && !rst && cur_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the data-memory request interface.
- Accepts one load/store request at a time from the pipeline's memory stage over a valid/ready handshake, waits a configurable number of wait-state cycles, then performs the access.
- Returns the result over a valid/ready response channel.
- Supports MIPS byte, halfword and word accesses with sign/zero extension, and flags misaligned or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the storage array.
- LATENCY, 2: wait-state cycles between request accept and the response becoming valid. 0 is legal.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  zero-extend loads (lbu/lhu)
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  access faulted

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Storage contents are not cleared by reset.
- req_ready=1 only in IDLE (combinational from state).
- Accept when req_valid && req_ready. All request fields are latched on accept.
- IDLE->WAIT on accept when LATENCY>0, with counter=LATENCY-1.
- IDLE->RESP on accept when LATENCY=0.
- WAIT: counter decrements each cycle; WAIT->RESP on the cycle the counter is 0.
- Access commit: the store write and the load array read happen on the clock edge that enters RESP. rsp_rdata and rsp_err are registered at that same edge.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
- RESP->IDLE on handshake. A new request can be accepted the cycle after the handshake, never in the same cycle (throughput = 1 request per LATENCY+2 cycles).
- Error conditions (any one raises rsp_err=1, suppresses the write, forces rsp_rdata=0):
  - size=11
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - addr<BASE_ADDR
  - ((addr-BASE_ADDR)>>2) >= DEPTH_WORDS
- Lane mapping is little-endian: byte lane k=addr[1:0] occupies bits 8k+7:8k; a half at addr[1]=h occupies bits 16h+15:16h.
- Stores:
  - sb writes only the selected byte from wdata[7:0].
  - sh writes the selected half from wdata[15:0].
  - sw writes the full word.
  - Unselected bytes are unchanged.
- Loads: extract the lane and right-justify it. Sign-extend when req_unsigned=0, zero-extend when req_unsigned=1. req_unsigned is ignored for words.
- Stores return rsp_rdata=0, rsp_err=0 when legal.
- Reset in WAIT: the request is dropped and the write is not performed.
- Reset in RESP: the write is already committed and the response is discarded.
- Input changes while not in IDLE are ignored.

Optional Feature:
- Macro DMEM_ERR_CAPTURE_EN.
- Defined: adds outputs err_sticky (1 bit) and err_addr (32 bits). On the first faulting access after reset, err_sticky<=1 and err_addr<=the faulting req_addr. Later faults do not overwrite either output. Both reset to 0 and are cleared only by rst.
- Not defined: the ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD)
  - state_t enum (IDLE, WAIT, RESP)
  - function to build a byte-enable mask from size/addr
- One sub-module, dmem_lane_align (combinational):
  - store path: shifts wdata into lane position and produces the 4-bit byte-enable
  - load path: extracts and extends the word into rsp_rdata
- Storage array and FSM stay in dmem_responder.

Test Plan:
- LATENCY=2: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid rises 3 cycles after accept.
- sb 0x13 data 0x80, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
- lh 0x11 -> rsp_err=1, rdata=0. sw 0x0E -> rsp_err=1 and word 0x0C is unchanged. Address DEPTH_WORDS*4 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, data stable, req_ready=0. Handshake, then a new request is accepted the next cycle.
- rst asserted in WAIT of sw 0x20 data 0x12345678 -> outputs at reset values next cycle; a subsequent lw 0x20 returns the prior content.
- With DMEM_ERR_CAPTURE_EN: faults at 0x31 then 0x45 -> err_sticky=1, err_addr=0x31.
